seg7_capture: RTL

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - debounced seven-segment pattern capture and hex decode
//
// Purpose: samples a seven-segment pattern bus, accepts a pattern once it has
// been stable for STABLE_CYCLES consecutive edges, decodes it to a hex digit
// and presents it on a valid/ready style output with status flags.
//
// Ports:
//   clk           design clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   ena           capture enable, low holds the block idle
//   seg_in[6:0]   segment pattern {g,f,e,d,c,b,a}, 1 = lit
//   digit_ready   consumer accepts digit_out when high with digit_valid
//   digit_out[3:0] decoded hex value of the last accepted table pattern
//   digit_valid   digit_out holds an unconsumed value
//   blank         last accepted pattern was all segments off
//   bad_pattern   sticky: an accepted pattern matched no table entry
//   overrun       sticky: a digit was overwritten before being consumed
//   change_count[7:0] number of accepted pattern changes, wraps

module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [6:0] seg_in,
  input  logic       digit_ready,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       blank,
  output logic       bad_pattern,
  output logic       overrun,
  output logic [7:0] change_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // The run counter holds (samples seen - 1), so the acceptance edge is the
  // one where an equal sample arrives with the counter at STABLE_CYCLES-2.
  localparam logic [3:0] LP_HIT = 4'(STABLE_CYCLES - 2);
  localparam logic [3:0] LP_MAX = 4'(STABLE_CYCLES);

  logic [1:0] r_state;
  logic [6:0] r_prev;
  logic [3:0] r_run;
  logic [6:0] r_last;
  logic       r_last_vld;
  logic [3:0] r_digit;
  logic       r_valid;
  logic       r_blank;
  logic       r_bad;
  logic       r_ovr;
  logic [7:0] r_cnt;

  logic       w_same;
  logic       w_hit;
  logic       w_new;
  logic       w_is_digit;
  logic [3:0] w_val;
  logic       w_take_digit;
  logic       w_consume;

  always_comb begin
    w_is_digit = 1'b1;
    w_val      = 4'h0;
    case (seg_in)
      7'h3F: w_val = 4'h0;
      7'h06: w_val = 4'h1;
      7'h5B: w_val = 4'h2;
      7'h4F: w_val = 4'h3;
      7'h66: w_val = 4'h4;
      7'h6D: w_val = 4'h5;
      7'h7D: w_val = 4'h6;
      7'h07: w_val = 4'h7;
      7'h7F: w_val = 4'h8;
      7'h6F: w_val = 4'h9;
      7'h77: w_val = 4'hA;
      7'h7C: w_val = 4'hB;
      7'h39: w_val = 4'hC;
      7'h5E: w_val = 4'hD;
      7'h79: w_val = 4'hE;
      7'h71: w_val = 4'hF;
      default: w_is_digit = 1'b0;
    endcase
  end

  assign w_same = (seg_in == r_prev);
  // The first enabled edge out of IDLE always counts as sample one, so a
  // pattern that sat on the bus while disabled still needs a full run.
  assign w_hit  = ena && (r_state != ST_IDLE) && w_same && (r_run == LP_HIT);
  // r_last_vld separates "nothing accepted yet" from a real 7'h7F (digit 8).
  assign w_new  = w_hit && !(r_last_vld && (seg_in == r_last));
  assign w_take_digit = w_new && w_is_digit;
  assign w_consume    = ena && r_valid && digit_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_prev     <= 7'h00;
      r_run      <= 4'd0;
      r_last     <= 7'h7F;
      r_last_vld <= 1'b0;
      r_digit    <= 4'h0;
      r_valid    <= 1'b0;
      r_blank    <= 1'b0;
      r_bad      <= 1'b0;
      r_ovr      <= 1'b0;
      r_cnt      <= 8'h00;
    end else begin
      r_prev <= seg_in;

      if (!ena || (r_state == ST_IDLE) || !w_same) begin
        r_run <= 4'd0;
      end else if (r_run != LP_MAX) begin
        r_run <= r_run + 4'd1;
      end

      if (!ena) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:   r_state <= ST_SETTLE;
          ST_SETTLE: if (w_hit) r_state <= ST_LOCKED;
          ST_LOCKED: if (!w_same) r_state <= ST_SETTLE;
          default:   r_state <= ST_IDLE;
        endcase
      end

      if (w_hit) begin
        r_last     <= seg_in;
        r_last_vld <= 1'b1;
      end

      if (w_new) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_is_digit) begin
          r_digit <= w_val;
          r_blank <= 1'b0;
          if (r_valid && !digit_ready) begin
            r_ovr <= 1'b1;
          end
        end else if (seg_in == 7'h00) begin
          r_blank <= 1'b1;
        end else begin
          r_bad   <= 1'b1;
          r_blank <= 1'b0;
        end
      end

      // A fresh digit on the consume edge keeps valid high with the new value.
      if (w_take_digit) begin
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign digit_out    = r_digit;
  assign digit_valid  = r_valid;
  assign blank        = r_blank;
  assign bad_pattern  = r_bad;
  assign overrun      = r_ovr;
  assign change_count = r_cnt;

endmodule
